// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 32x32 multiply / divide unit owning HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle, followed by
// a single sign-fixup cycle. MTHI/MTLO write in one cycle; MFHI/MFLO read
// back combinationally through moveResult.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] moveResult,
  output logic             divByZero
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  // Context of the operation in flight, needed again at fixup.
  typedef struct packed {
    logic is_div;
    logic is_signed;
    logic neg_a;
    logic neg_b;
  } op_ctx_t;

  state_t   state, state_next;
  op_ctx_t  ctx;
  logic [4:0]  cnt;
  logic [63:0] acc;     // product, or {unused, quotient/dividend} when dividing
  logic [31:0] mcand;   // multiplicand magnitude, or divisor magnitude
  logic [31:0] rem;     // partial remainder (always < divisor)
  logic [31:0] a_raw;   // raw dividend, returned in HI on divide-by-zero
  logic [31:0] hi_q, lo_q;
  logic        done_q, dbz_q;

  logic accept_mul, accept_div, write_hi, write_lo;

  // Next-state and request decode.
  always_comb begin
    state_next = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU: begin accept_mul = 1'b1; state_next = MUL; end
            F_DIV,  F_DIVU:  begin accept_div = 1'b1; state_next = DIV; end
            F_MTHI:          write_hi = 1'b1;
            F_MTLO:          write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MUL, DIV: if (cnt == 5'd31) state_next = FIX;
      FIX:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand conditioning at accept: signed ops keep magnitudes plus signs.
  logic        req_signed, req_neg_a, req_neg_b;
  logic [31:0] mag_a, mag_b;
  always_comb begin
    req_signed = ~funct[0];
    req_neg_a  = req_signed & operandA[31];
    req_neg_b  = req_signed & operandB[31];
    mag_a      = req_neg_a ? (32'd0 - operandA) : operandA;
    mag_b      = req_neg_b ? (32'd0 - operandB) : operandB;
  end

  // One iteration step for each algorithm.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    div_shift = {rem, acc[31]};
    div_ge    = (div_shift >= {1'b0, mcand});
  end

  // Fixup results: sign correction and the divide-by-zero override.
  logic [63:0] prod_fix;
  logic [31:0] fix_hi, fix_lo;
  logic        div_zero;
  always_comb begin
    div_zero = (mcand == 32'd0);
    prod_fix = (ctx.is_signed && (ctx.neg_a ^ ctx.neg_b)) ? (64'd0 - acc) : acc;
    if (!ctx.is_div) begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end else if (div_zero) begin
      fix_hi = a_raw;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_lo = (ctx.is_signed && (ctx.neg_a ^ ctx.neg_b)) ? (32'd0 - acc[31:0]) : acc[31:0];
      fix_hi = (ctx.is_signed && ctx.neg_a) ? (32'd0 - rem) : rem;
    end
  end

  // Datapath, HI/LO and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctx    <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      rem    <= '0;
      a_raw  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      if (accept_mul || accept_div) begin
        ctx   <= '{is_div: accept_div, is_signed: req_signed,
                   neg_a: req_neg_a, neg_b: req_neg_b};
        cnt   <= '0;
        acc   <= accept_div ? {32'd0, mag_a} : {32'd0, mag_b};
        mcand <= accept_div ? mag_b : mag_a;
        rem   <= '0;
        a_raw <= operandA;
        dbz_q <= 1'b0;
      end
      if (write_hi) hi_q <= operandA;
      if (write_lo) lo_q <= operandA;
      case (state)
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
        end
        DIV: begin
          rem        <= div_ge ? 32'(div_shift - {1'b0, mcand}) : div_shift[31:0];
          acc[31:0]  <= {acc[30:0], div_ge};
          cnt        <= cnt + 5'd1;
        end
        FIX: begin
          hi_q  <= fix_hi;
          lo_q  <= fix_lo;
          dbz_q <= ctx.is_div & div_zero;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign divByZero  = dbz_q;
  assign moveResult = (funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the latched operands (`readData1Out`, `readData2Out`), `functOut` and the `hitOut` qualifier, and owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU over 33 cycles while holding `busy` to stall the pipeline. MTHI/MTLO complete in one cycle, and MFHI/MFLO read back combinationally.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported; it exists for documentation only.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request qualifier. Driven by `hitOut` of ID/EX.
- `funct`, in, 6: operation select. MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other code is ignored.
- `operandA`, in, 32: rs value / dividend / MTHI-MTLO source.
- `operandB`, in, 32: rt value / divisor.
- `busy`, out, 1: high while a multiply or divide is in progress. The pipeline stalls on it.
- `done`, out, 1: one-cycle registered pulse marking the cycle HI/LO first show a new mul/div result.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.
- `moveResult`, out, 32: combinational. Equals `hi` when `funct`=0x10, otherwise `lo`.
- `divByZero`, out, 1: sticky flag for the last completed divide.

## Operation
- States: IDLE, MUL, DIV, FIX.
- **Accept**: a request is accepted when `start`=1 and state=IDLE.
  - MULT/MULTU: go to MUL.
  - DIV/DIVU: go to DIV.
  - Signed ops capture operand magnitudes plus the sign of each operand. Unsigned ops capture operands raw.
  - Iteration counter is set to 0. `divByZero` is cleared.
- **Ignored requests**: `start` while busy is ignored; the upstream stall must hold the request. Unrecognised `funct` is ignored.
- **MTHI/MTLO** (0x11/0x13) accepted in IDLE: write `operandA` to HI/LO at that edge. `busy` and `done` are unaffected. While busy, MTHI/MTLO are ignored.
- **MUL**: shift-add, one multiplier bit per cycle, 32 iterations, 64-bit accumulator. After the 32nd iteration go to FIX.
- **DIV**: restoring divide, one quotient bit per cycle, 32 iterations, 33-bit partial remainder. After the 32nd iteration go to FIX.
- **FIX**, single cycle, always returns to IDLE:
  - Multiply: product is negated if signed and the operand signs differ. HI = upper 32 bits, LO = lower 32 bits.
  - Divide: LO = quotient, negated if signed and signs differ. HI = remainder, carrying the dividend's sign if signed.
  - Arithmetic is modulo 2^32 per half. 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divisor = 0: LO=0xFFFFFFFF, HI=captured `operandA`, `divByZero`=1. Latency is unchanged.
- **Reset** (asynchronous, any state, including mid-operation):
  - State=IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, `divByZero`=0.
  - An operation in flight is discarded; HI/LO do not retain partial values.

## Timing
- Accept edge E0: `busy`=1 from E0 onward.
- Iterations occur at E1..E32. FIX occurs at E33.
- After E33: HI/LO hold the result, `done`=1 for exactly one cycle, `busy`=0.
- `busy` is high for exactly 33 cycles.
- A new `start` is accepted at E33+1 at the earliest; the cycle with `done`=1 is itself IDLE. Back-to-back ops therefore have a 34-cycle period.
- `moveResult` has no latency. An MFHI/MFLO issued in the `done` cycle sees the new value.
- MTHI/MTLO: visible on `hi`/`lo` the cycle after the accept edge.
- `done` and `busy` are never both high.

## Test plan
- Reset: assert `reset` asynchronously mid-MUL at iteration 10 → `busy`, `done`, `hi`, `lo` drop to 0 immediately, without a clock edge. After release, the unit is in IDLE and accepts a new op.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, `done` pulse, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5, `divByZero`=1, 33-cycle latency. The next accepted MULT clears `divByZero` at its accept edge.
- MTLO 0x1234 in IDLE → `lo`=0x1234 the next cycle, with no `busy`/`done`. A MTHI or second MULT asserted while busy → ignored, result unchanged. MFHI in the `done` cycle → `moveResult`=new HI.
